// File: rtl/cpu_instr_encoder.sv
// ============================================================================
// Module   : cpu_instr_encoder
// Brief    : Encodes decoded instruction fields (R / ADDI / J / BNE) into
//            32-bit instruction words and assigns sequential word addresses
//            for the instruction-memory loader. Results pass through a
//            2-entry output FIFO. A small sequencer frames each program
//            (in_last -> drain -> prog_done).
// Options  : CPU_ENC_RANGE_CHECK_EN - when defined, enc_err is a sticky flag
//            raised by any accepted field that does not fit its encoding.
//            When undefined, enc_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cpu_instr_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [31:0]       in_imm,
  input  logic [31:0]       in_target,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              prog_done,
  output logic              enc_err
);

  // Program start address, truncated to the address width
  localparam logic [ADDR_W-1:0] c_base_addr = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);

  // Field-kind codes on in_kind
  localparam logic [1:0] c_kind_r   = 2'd0;
  localparam logic [1:0] c_kind_i   = 2'd1;
  localparam logic [1:0] c_kind_j   = 2'd2;
  localparam logic [1:0] c_kind_bne = 2'd3;

  // Opcodes and the R-type function code (ADD)
  localparam logic [5:0] c_op_r      = 6'b000000;
  localparam logic [5:0] c_op_addi   = 6'b001000;
  localparam logic [5:0] c_op_j      = 6'b000010;
  localparam logic [5:0] c_op_bne    = 6'b000101;
  localparam logic [5:0] c_funct_add = 6'b100000;

  localparam logic [1:0] c_fifo_full = 2'd2;

  // Program sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_in_ready;
  logic                r_prog_done;
  logic [ADDR_W-1:0]   r_addr_cnt;

  // Two-entry output FIFO storage: each entry is {instr, addr, last}
  logic [31:0]         r_fifo_instr [2];
  logic [ADDR_W-1:0]   r_fifo_addr  [2];
  logic                r_fifo_last  [2];
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [1:0]          r_count;

  logic [31:0]         w_instr;
  logic                w_push;
  logic                w_pop;
  logic                w_head_last;
  logic [1:0]          w_count_nxt;

  // Handshakes: accept only while advertised ready, emit whenever FIFO holds data
  assign w_push      = in_valid && r_in_ready;
  assign w_pop       = (r_count != 2'd0) && out_ready;
  assign w_head_last = r_fifo_last[r_rd_ptr];

  // Pack the decoded fields into the machine word; oversized fields are truncated
  always_comb begin
    w_instr = '0;
    case (in_kind)
      c_kind_r: w_instr = {c_op_r, in_rs, in_rt, in_rd, 5'd0, c_funct_add};
      c_kind_i: w_instr = {c_op_addi, in_rs, in_rt, in_imm[15:0]};
      c_kind_j: w_instr = {c_op_j, in_target[25:0]};
      default:  w_instr = {c_op_bne, in_rs, in_rt, in_imm[15:0]};
    endcase
  end

  // Occupancy after this cycle; push+pop together leaves it unchanged
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 2'd1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 2'd1;
    end
  end

  // FIFO storage and pointers; the head entry drives the outputs directly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fifo_instr[0] <= '0;
      r_fifo_instr[1] <= '0;
      r_fifo_addr[0]  <= c_base_addr;
      r_fifo_addr[1]  <= c_base_addr;
      r_fifo_last[0]  <= 1'b0;
      r_fifo_last[1]  <= 1'b0;
      r_wr_ptr        <= 1'b0;
      r_rd_ptr        <= 1'b0;
      r_count         <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo_instr[r_wr_ptr] <= w_instr;
        r_fifo_addr[r_wr_ptr]  <= r_addr_cnt;
        r_fifo_last[r_wr_ptr]  <= in_last;
        r_wr_ptr               <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= w_count_nxt;
    end
  end

  // Sequencer next state: a last word closes the program, its pop finishes it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_STREAM: begin
        if (w_push) begin
          w_state_nxt = in_last ? ST_DRAIN : ST_STREAM;
        end
      end
      ST_DRAIN: begin
        if (w_pop && w_head_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Sequencer state, registered ready / done, and the program address counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_prog_done <= 1'b0;
      r_addr_cnt  <= c_base_addr;
    end else begin
      r_state     <= w_state_nxt;
      // Pulse for exactly the DONE cycle
      r_prog_done <= (r_state == ST_DRAIN) && (w_state_nxt == ST_DONE);
      // No new program words while a finished program drains or closes
      r_in_ready  <= (w_count_nxt != c_fifo_full) &&
                     ((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_STREAM));
      // Push and DONE never coincide because in_ready is low in DONE
      if (r_state == ST_DONE) begin
        r_addr_cnt <= c_base_addr;
      end else if (w_push) begin
        r_addr_cnt <= r_addr_cnt + c_addr_one;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_count != 2'd0);
  assign out_instr = r_fifo_instr[r_rd_ptr];
  assign out_addr  = r_fifo_addr[r_rd_ptr];
  assign prog_done = r_prog_done;

`ifdef CPU_ENC_RANGE_CHECK_EN
  logic w_range_bad;
  logic r_enc_err;

  // Field does not fit: J target above 26 bits, or imm not a sign-extended 16-bit value
  always_comb begin
    w_range_bad = 1'b0;
    case (in_kind)
      c_kind_j:             w_range_bad = (in_target[31:26] != 6'd0);
      c_kind_i, c_kind_bne: w_range_bad = (in_imm[31:16] != {16{in_imm[15]}});
      default:              w_range_bad = 1'b0;
    endcase
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_enc_err <= 1'b0;
    end else if (w_push && w_range_bad) begin
      r_enc_err <= 1'b1;
    end
  end

  assign enc_err = r_enc_err;
`else
  // Upper field bits are intentionally ignored when no range check is built
  logic w_unused_hi;
  assign w_unused_hi = &{1'b0, in_target[31:26], in_imm[31:16]};
  assign enc_err     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cpu_instr_encoder.sv
// ============================================================================
// Module   : tb_cpu_instr_encoder
// Brief    : Scoreboard bench for cpu_instr_encoder. The stimulus side pushes
//            expected {instr, addr, last} entries; a negedge monitor compares
//            the FIFO head against the queue front and pops on transfer.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cpu_instr_encoder;

  localparam int ADDR_W    = 10;
  localparam int BASE_ADDR = 0;
  localparam int ADDR_MOD  = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_kind;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [31:0]       in_imm;
  logic [31:0]       in_target;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              prog_done;
  logic              enc_err;

  cpu_instr_encoder #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kind   (in_kind),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_imm    (in_imm),
    .in_target (in_target),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .prog_done (prog_done),
    .enc_err   (enc_err)
  );

  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] addr;
    logic              last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks       = 0;
  int   failures     = 0;
  int   prog_idx     = 0;
  bit   exp_err      = 1'b0;
  bit   done_pending = 1'b0;
  int   rdy_mode     = 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output-side back-pressure: 0 = stall, 1 = always ready, 2 = random
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Reference encoding built from field positions with plain arithmetic
  function automatic logic [31:0] model_instr(input logic [1:0] k, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] imm, input logic [31:0] tgt);
    logic [31:0] regs;
    regs = (32'(rs) << 21) + (32'(rt) << 16);
    case (k)
      2'd0:    return regs + (32'(rd) << 11) + 32'd32;
      2'd1:    return (32'd8 << 26) + regs + (imm % 32'h10000);
      2'd2:    return (32'd2 << 26) + (tgt % 32'h0400_0000);
      default: return (32'd5 << 26) + regs + (imm % 32'h10000);
    endcase
  endfunction

  function automatic bit model_err(input logic [1:0] k, input logic [31:0] imm, input logic [31:0] tgt);
    int s;
    s = $signed(imm);
    if (k == 2'd2) return (tgt >= 32'h0400_0000);
    if (k == 2'd0) return 1'b0;
    return (s < -32768) || (s > 32767);
  endfunction

  // Offer one field set, wait (bounded) for acceptance, record the expectation
  task automatic send(input logic [1:0] k, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [31:0] imm, input logic [31:0] tgt,
      input logic last, input logic [31:0] exp_instr);
    bit   acc;
    exp_t e;
    in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd;
    in_imm = imm; in_target = tgt; in_last = last;
    in_valid = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        acc = 1'b1;
        break;
      end
    end
    if (!acc) begin
      fail_now("accept_timeout");
    end else begin
      e.instr = exp_instr;
      e.addr  = ADDR_W'((BASE_ADDR + prog_idx) % ADDR_MOD);
      e.last  = last;
      sb.push_back(e);
      prog_idx = last ? 0 : prog_idx + 1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
`ifdef CPU_ENC_RANGE_CHECK_EN
    if (acc && model_err(k, imm, tgt)) exp_err = 1'b1;
`endif
  endtask

  task automatic send_rand(input logic last);
    logic [1:0]  k;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm, tgt;
    k   = 2'($urandom_range(0, 3));
    rs  = 5'($urandom);
    rt  = 5'($urandom);
    rd  = 5'($urandom);
    imm = $urandom;
    tgt = $urandom;
    if ($urandom_range(0, 1) == 1) imm = {{16{imm[15]}}, imm[15:0]};
    if ($urandom_range(0, 1) == 1) tgt = tgt % 32'h0400_0000;
    send(k, rs, rt, rd, imm, tgt, last, model_instr(k, rs, rt, rd, imm, tgt));
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 3000 && sb.size() != 0; n++) @(posedge clk);
    if (sb.size() != 0) fail_now("drain_timeout");
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Assert reset between edges, check the asynchronous clear, release after an edge
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    prog_idx = 0;
    exp_err  = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_prog_done", 64'(prog_done), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_out_addr", 64'(out_addr), 64'(BASE_ADDR));
    chk("rst_enc_err", 64'(enc_err), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_release_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
  endtask

  // Monitor: head must match the queue front every valid cycle; pop on transfer
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      done_pending = 1'b0;
    end else begin
      chk("prog_done", 64'(prog_done), 64'(done_pending));
      chk("enc_err", 64'(enc_err), 64'(exp_err));
      done_pending = 1'b0;
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%0h required=none", out_instr);
        end else begin
          chk("out_instr", 64'(out_instr), 64'(sb[0].instr));
          chk("out_addr", 64'(out_addr), 64'(sb[0].addr));
          if (out_ready) begin
            mon_e        = sb.pop_front();
            done_pending = mon_e.last;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_imm = '0; in_target = '0; in_last = 1'b0; out_ready = 1'b0;
    rdy_mode = 1;
    do_reset();

    // Single-word R program right after reset; out_valid the cycle after accept
    send(2'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0, 1'b1, 32'h0022_1820);
    chk("latency_out_valid", 64'(out_valid), 64'd1);
    wait_drain();

    // Three-word program, then a new program restarting at the base address
    send(2'd1, 5'd4, 5'd5, 5'd0, 32'h10, 32'd0, 1'b0, 32'h2085_0010);
    send(2'd2, 5'd0, 5'd0, 5'd0, 32'd0, 32'h40, 1'b0, 32'h0800_0040);
    send(2'd3, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFE, 32'd0, 1'b1, 32'h1422_FFFE);
    wait_drain();
    send(2'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0, 1'b1, 32'h0022_1820);
    wait_drain();

    // Stall: two words fill the FIFO, ready drops, head stays put
    rdy_mode = 0;
    send(2'd0, 5'd7, 5'd8, 5'd9, 32'd0, 32'd0, 1'b0, model_instr(2'd0, 5'd7, 5'd8, 5'd9, 32'd0, 32'd0));
    send(2'd1, 5'd31, 5'd30, 5'd0, 32'h7FFF, 32'd0, 1'b0, model_instr(2'd1, 5'd31, 5'd30, 5'd0, 32'h7FFF, 32'd0));
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    repeat (3) @(posedge clk);
    rdy_mode = 1;
    send(2'd2, 5'd0, 5'd0, 5'd0, 32'd0, 32'h03FF_FFFF, 1'b1, 32'h0BFF_FFFF);
    wait_drain();

    // Reset while draining a closed program with two words queued
    rdy_mode = 0;
    send(2'd0, 5'd3, 5'd3, 5'd3, 32'd0, 32'd0, 1'b0, model_instr(2'd0, 5'd3, 5'd3, 5'd3, 32'd0, 32'd0));
    send(2'd0, 5'd4, 5'd4, 5'd4, 32'd0, 32'd0, 1'b1, model_instr(2'd0, 5'd4, 5'd4, 5'd4, 32'd0, 32'd0));
    do_reset();
    rdy_mode = 1;
    send(2'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0, 1'b1, 32'h0022_1820);
    wait_drain();

    // Out-of-range J target: word truncated; enc_err only when checking is built
    send(2'd2, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0400_0000, 1'b1, 32'h0800_0000);
    wait_drain();

    // Long program: addresses wrap modulo the address space
    for (int i = 0; i < ADDR_MOD + 6; i++) send_rand(i == ADDR_MOD + 5);
    wait_drain();

    // Random programs under random back-pressure
    rdy_mode = 2;
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int w = 0; w < len; w++) send_rand(w == len - 1);
    end
    rdy_mode = 1;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
